// File: rtl/ahb_rr_burst_arbiter.sv
// ahb_rr_burst_arbiter
// Round-robin AHB arbiter for one slave port. A granted master keeps the
// port until its transfer or burst completes (fixed-length beat count,
// INCR ended by the master, or early termination). hmaster drives the
// slave-side address/data mux select.
//
// Optional build macro AHB_ARB_HOLD_TIMEOUT_EN: an owner sitting in OWNED
// issuing IDLE transfers is forced off the port after HOLD_LIMIT accepted
// IDLEs whenever another master is requesting.
module ahb_rr_burst_arbiter #(
    parameter int SLAVE_X_MASTER_NUM = 4,
    parameter int MASTER_ID_BIT      = $clog2(SLAVE_X_MASTER_NUM),
    parameter int HOLD_LIMIT         = 16
) (
    input  logic                          hclk,
    input  logic                          hreset_n,
    input  logic [SLAVE_X_MASTER_NUM-1:0] hreq,
    input  logic [1:0]                    htrans,
    input  logic [2:0]                    hburst,
    input  logic                          hready,
    output logic [SLAVE_X_MASTER_NUM-1:0] hgrant,
    output logic [MASTER_ID_BIT-1:0]      hmaster,
    output logic                          hsel,
    output logic                          burst_active
);

    localparam int N = SLAVE_X_MASTER_NUM;

    // AHB transfer types
    localparam logic [1:0] TRANS_IDLE   = 2'd0;
    localparam logic [1:0] TRANS_NONSEQ = 2'd2;
    localparam logic [1:0] TRANS_SEQ    = 2'd3;

    // AHB burst types
    localparam logic [2:0] BURST_SINGLE = 3'd0;
    localparam logic [2:0] BURST_INCR   = 3'd1;
    localparam logic [2:0] BURST_WRAP4  = 3'd2;
    localparam logic [2:0] BURST_INCR4  = 3'd3;
    localparam logic [2:0] BURST_WRAP8  = 3'd4;
    localparam logic [2:0] BURST_INCR8  = 3'd5;
    localparam logic [2:0] BURST_WRAP16 = 3'd6;
    localparam logic [2:0] BURST_INCR16 = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_BURST = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [N-1:0]             grant_d;
    logic [MASTER_ID_BIT-1:0] master_d;
    logic [MASTER_ID_BIT-1:0] last_q, last_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     incr_q, incr_d;
    logic                     rearb;
    logic                     owner_req;
    logic [MASTER_ID_BIT-1:0] win;

`ifdef AHB_ARB_HOLD_TIMEOUT_EN
    localparam logic [4:0] HOLD_CNT = 5'(HOLD_LIMIT);
    logic [4:0] idle_cnt_q, idle_cnt_d;
    logic       other_req;
`endif

    // First requester found scanning ptr+1, ptr+2, ... modulo N. The previous
    // winner (ptr) is therefore always the lowest-priority candidate.
    function automatic logic [MASTER_ID_BIT-1:0] rr_pick(
        input logic [N-1:0]             req,
        input logic [MASTER_ID_BIT-1:0] ptr
    );
        logic [MASTER_ID_BIT-1:0] sel;
        logic                     found;
        int                       idx;
        sel   = ptr;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                sel   = MASTER_ID_BIT'(idx);
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [N-1:0] to_onehot(input logic [MASTER_ID_BIT-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Remaining SEQ beats after the NONSEQ of a fixed-length burst
    function automatic logic [3:0] beat_load(input logic [2:0] burst);
        logic [3:0] n;
        case (burst)
            BURST_WRAP4,  BURST_INCR4:  n = 4'd3;
            BURST_WRAP8,  BURST_INCR8:  n = 4'd7;
            BURST_WRAP16, BURST_INCR16: n = 4'd15;
            default:                    n = 4'd0;
        endcase
        return n;
    endfunction

    assign win          = rr_pick(hreq, last_q);
    assign owner_req    = |(hreq & hgrant);
    assign hsel         = |hgrant;
    assign burst_active = (state_q == ST_BURST);

`ifdef AHB_ARB_HOLD_TIMEOUT_EN
    assign other_req = |(hreq & ~hgrant);
`endif

    // State, grant, round-robin pointer and beat counter registers
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state_q <= ST_IDLE;
            hgrant  <= '0;
            hmaster <= '0;
            last_q  <= MASTER_ID_BIT'(N - 1);
            cnt_q   <= '0;
            incr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hgrant  <= grant_d;
            hmaster <= master_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            incr_q  <= incr_d;
        end
    end

`ifdef AHB_ARB_HOLD_TIMEOUT_EN
    // Count of accepted IDLE transfers while the owner holds the port
    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

    // Next-state logic: decide when ownership ends and who wins next.
    // Nothing moves unless the slave accepts the transfer (hready=1).
    always_comb begin
        state_d  = state_q;
        grant_d  = hgrant;
        master_d = hmaster;
        last_d   = last_q;
        cnt_d    = cnt_q;
        incr_d   = incr_q;
        rearb    = 1'b0;
`ifdef AHB_ARB_HOLD_TIMEOUT_EN
        idle_cnt_d = idle_cnt_q;
`endif
        if (hready) begin
            case (state_q)
                ST_IDLE: begin
                    rearb = 1'b1;
                end
                ST_OWNED: begin
                    if (htrans == TRANS_NONSEQ) begin
`ifdef AHB_ARB_HOLD_TIMEOUT_EN
                        idle_cnt_d = '0;
`endif
                        if (hburst == BURST_SINGLE) begin
                            rearb = 1'b1;
                        end else if (hburst == BURST_INCR) begin
                            state_d = ST_BURST;
                            incr_d  = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            state_d = ST_BURST;
                            incr_d  = 1'b0;
                            cnt_d   = beat_load(hburst);
                        end
                    end else if (htrans == TRANS_IDLE && !owner_req) begin
                        rearb = 1'b1;
                    end
`ifdef AHB_ARB_HOLD_TIMEOUT_EN
                    else begin
                        // Saturate so a lone owner can keep idling forever
                        if (htrans == TRANS_IDLE && idle_cnt_q < HOLD_CNT) begin
                            idle_cnt_d = idle_cnt_q + 5'd1;
                        end
                        if (idle_cnt_d >= HOLD_CNT && other_req) begin
                            rearb = 1'b1;
                        end
                    end
`endif
                end
                ST_BURST: begin
                    if (incr_q) begin
                        if ((htrans == TRANS_IDLE || htrans == TRANS_NONSEQ) && !owner_req) begin
                            rearb = 1'b1;
                        end
                    end else begin
                        case (htrans)
                            // The SEQ seen with one beat left is the final beat
                            TRANS_SEQ: begin
                                if (cnt_q <= 4'd1) begin
                                    rearb = 1'b1;
                                end else begin
                                    cnt_d = cnt_q - 4'd1;
                                end
                            end
                            TRANS_IDLE, TRANS_NONSEQ: begin
                                rearb = 1'b1;
                            end
                            default: begin
                                cnt_d = cnt_q;
                            end
                        endcase
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // A re-won owner always restarts in OWNED, never straight in BURST
        if (rearb) begin
            incr_d = 1'b0;
            cnt_d  = '0;
`ifdef AHB_ARB_HOLD_TIMEOUT_EN
            idle_cnt_d = '0;
`endif
            if (|hreq) begin
                state_d  = ST_OWNED;
                grant_d  = to_onehot(win);
                master_d = win;
                last_d   = win;
            end else begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        end
    end

endmodule

// File: tb/tb_ahb_rr_burst_arbiter.sv
// Self-checking bench for ahb_rr_burst_arbiter (4 masters).
// Directed scenarios followed by random traffic, all compared against a
// transaction-level reference model of ownership and burst progress.
module tb_ahb_rr_burst_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 16;

    localparam logic [1:0] T_IDLE   = 2'd0;
    localparam logic [1:0] T_NONSEQ = 2'd2;
    localparam logic [1:0] T_SEQ    = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0;
    localparam logic [2:0] B_INCR4  = 3'd3;
    localparam logic [2:0] B_WRAP8  = 3'd4;
    localparam logic [2:0] B_INCR8  = 3'd5;

    logic         hclk = 1'b0;
    logic         hreset_n;
    logic [N-1:0] hreq;
    logic [1:0]   htrans;
    logic [2:0]   hburst;
    logic         hready;
    logic [N-1:0] hgrant;
    logic [1:0]   hmaster;
    logic         hsel;
    logic         burst_active;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the port and how much of the burst remains
    int m_owner;      // -1 when nobody owns the port
    int m_last;
    int m_master;
    bit m_in_burst;
    bit m_undef_len;
    int m_beats_left;
    int m_idles;

    always #5 hclk = ~hclk;

    ahb_rr_burst_arbiter #(
        .SLAVE_X_MASTER_NUM(N),
        .MASTER_ID_BIT     (2),
        .HOLD_LIMIT        (HOLD)
    ) dut (
        .hclk        (hclk),
        .hreset_n    (hreset_n),
        .hreq        (hreq),
        .htrans      (htrans),
        .hburst      (hburst),
        .hready      (hready),
        .hgrant      (hgrant),
        .hmaster     (hmaster),
        .hsel        (hsel),
        .burst_active(burst_active)
    );

    function automatic int pick(input logic [N-1:0] req, input int from);
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (from + k) % N;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic int burst_len(input logic [2:0] b);
        case (b)
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            3'd6, 3'd7: return 16;
            default:    return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_owner      = -1;
        m_last       = N - 1;
        m_master     = 0;
        m_in_burst   = 0;
        m_undef_len  = 0;
        m_beats_left = 0;
        m_idles      = 0;
    endtask

    // Apply one clock edge worth of bus activity to the model
    task automatic model_edge(input logic [N-1:0] req, input logic [1:0] tr,
                              input logic [2:0] bu, input logic rdy);
        bit rearb;
        bit own_req;
        int w;
        rearb = 0;
        if (!rdy) return;
        own_req = (m_owner >= 0) ? req[m_owner] : 1'b0;
        if (m_owner < 0) begin
            rearb = 1;
        end else if (!m_in_burst) begin
            if (tr == T_NONSEQ) begin
                m_idles = 0;
                if (bu == B_SINGLE) begin
                    rearb = 1;
                end else if (bu == 3'd1) begin
                    m_in_burst  = 1;
                    m_undef_len = 1;
                end else begin
                    m_in_burst   = 1;
                    m_undef_len  = 0;
                    m_beats_left = burst_len(bu) - 1;
                end
            end else if (tr == T_IDLE && !own_req) begin
                rearb = 1;
            end else begin
`ifdef AHB_ARB_HOLD_TIMEOUT_EN
                if (tr == T_IDLE && m_idles < HOLD) m_idles++;
                if (m_idles >= HOLD && (req & ~(4'b0001 << m_owner)) != 0) rearb = 1;
`endif
            end
        end else if (m_undef_len) begin
            if ((tr == T_IDLE || tr == T_NONSEQ) && !own_req) rearb = 1;
        end else begin
            if (tr == T_SEQ) begin
                m_beats_left--;
                if (m_beats_left <= 0) rearb = 1;
            end else if (tr == T_IDLE || tr == T_NONSEQ) begin
                rearb = 1;
            end
        end
        if (rearb) begin
            m_in_burst  = 0;
            m_undef_len = 0;
            m_idles     = 0;
            w = pick(req, m_last);
            if (w >= 0) begin
                m_owner  = w;
                m_last   = w;
                m_master = w;
            end else begin
                m_owner = -1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        logic [31:0] eg;
        eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        chk({tag, ".hgrant"},       32'(hgrant),       eg);
        chk({tag, ".hmaster"},      32'(hmaster),      32'(m_master));
        chk({tag, ".hsel"},         32'(hsel),         32'(m_owner >= 0));
        chk({tag, ".burst_active"}, 32'(burst_active), 32'(m_in_burst));
    endtask

    task automatic step(input logic [N-1:0] r, input logic [1:0] t, input logic [2:0] b,
                        input logic rdy, input string tag);
        @(negedge hclk);
        hreq   = r;
        htrans = t;
        hburst = b;
        hready = rdy;
        @(posedge hclk);
        model_edge(r, t, b, rdy);
        #1;
        check_model(tag);
    endtask

    initial begin
        logic [N-1:0] rot [5];
        logic [N-1:0] r;
        logic [1:0]   t;
        logic [2:0]   b;
        logic         rdy;
        rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Reset values
        hreset_n = 1'b0;
        hreq     = '0;
        htrans   = T_IDLE;
        hburst   = B_SINGLE;
        hready   = 1'b0;
        model_reset();
        #1;
        chk("rst_hgrant",       32'(hgrant),       32'd0);
        chk("rst_hmaster",      32'(hmaster),      32'd0);
        chk("rst_hsel",         32'(hsel),         32'd0);
        chk("rst_burst_active", 32'(burst_active), 32'd0);
        @(negedge hclk);
        @(negedge hclk);
        hreset_n = 1'b1;

        // First grant after one edge
        step(4'b0110, T_IDLE, B_SINGLE, 1'b1, "first");
        chk("first_grant",  32'(hgrant),  32'b0010);
        chk("first_master", 32'(hmaster), 32'd1);

        // INCR4 by master 1, handover after the 4th beat
        step(4'b0110, T_NONSEQ, B_INCR4, 1'b1, "incr4_b1");
        chk("incr4_b1_grant", 32'(hgrant),       32'b0010);
        chk("incr4_b1_ba",    32'(burst_active), 32'd1);
        step(4'b0110, T_SEQ, B_INCR4, 1'b1, "incr4_b2");
        step(4'b0110, T_SEQ, B_INCR4, 1'b1, "incr4_b3");
        chk("incr4_b3_grant", 32'(hgrant), 32'b0010);
        step(4'b0110, T_SEQ, B_INCR4, 1'b1, "incr4_b4");
        chk("incr4_handover", 32'(hgrant),       32'b0100);
        chk("incr4_ba_drop",  32'(burst_active), 32'd0);

        // INCR4 by master 2 with three wait states on beat 2
        step(4'b0110, T_NONSEQ, B_INCR4, 1'b1, "wait_b1");
        for (int i = 0; i < 3; i++) step(4'b0110, T_SEQ, B_INCR4, 1'b0, "wait_hold");
        chk("wait_grant_held", 32'(hgrant), 32'b0100);
        step(4'b0110, T_SEQ, B_INCR4, 1'b1, "wait_b2");
        step(4'b0110, T_SEQ, B_INCR4, 1'b1, "wait_b3");
        chk("wait_b3_grant", 32'(hgrant), 32'b0100);
        step(4'b0110, T_SEQ, B_INCR4, 1'b1, "wait_b4");
        chk("wait_handover", 32'(hgrant), 32'b0010);

        // WRAP8 terminated early by IDLE, next requester master 3
        step(4'b1001, T_NONSEQ, B_WRAP8, 1'b1, "wrap8_b1");
        step(4'b1001, T_SEQ, B_WRAP8, 1'b1, "wrap8_b2");
        step(4'b1001, T_SEQ, B_WRAP8, 1'b1, "wrap8_b3");
        chk("wrap8_ba_mid", 32'(burst_active), 32'd1);
        step(4'b1001, T_IDLE, B_WRAP8, 1'b1, "wrap8_term");
        chk("wrap8_next_grant", 32'(hgrant),       32'b1000);
        chk("wrap8_ba_drop",    32'(burst_active), 32'd0);

        // All requesting, single transfers rotate the grant
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, T_NONSEQ, B_SINGLE, 1'b1, "rot");
            chk($sformatf("rot_%0d", i), 32'(hgrant), 32'(rot[i]));
        end

        // Owner 0 idles while master 2 requests
`ifdef AHB_ARB_HOLD_TIMEOUT_EN
        for (int i = 1; i <= HOLD; i++) begin
            step(4'b0101, T_IDLE, B_SINGLE, 1'b1, "hold");
            if (i == HOLD - 1) chk("hold_before_limit", 32'(hgrant), 32'b0001);
        end
        chk("hold_release", 32'(hgrant), 32'b0100);
`else
        for (int i = 1; i <= 100; i++) step(4'b0101, T_IDLE, B_SINGLE, 1'b1, "hold");
        chk("hold_kept", 32'(hgrant), 32'b0001);
`endif

        // Asynchronous reset in the middle of a burst
        step(4'b0110, T_NONSEQ, B_INCR8, 1'b1, "arst_b1");
        step(4'b0110, T_SEQ, B_INCR8, 1'b1, "arst_b2");
        chk("arst_ba_pre", 32'(burst_active), 32'd1);
        @(negedge hclk);
        #2;
        hreset_n = 1'b0;
        #1;
        model_reset();
        chk("arst_hgrant",       32'(hgrant),       32'd0);
        chk("arst_hmaster",      32'(hmaster),      32'd0);
        chk("arst_hsel",         32'(hsel),         32'd0);
        chk("arst_burst_active", 32'(burst_active), 32'd0);
        hready = 1'b0;
        @(negedge hclk);
        hreset_n = 1'b1;
        step(4'b0110, T_IDLE, B_SINGLE, 1'b1, "arst_regrant");
        chk("arst_ptr_reset", 32'(hgrant), 32'b0010);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            r   = 4'($urandom_range(0, 15));
            t   = 2'($urandom_range(0, 3));
            b   = 3'($urandom_range(0, 7));
            rdy = ($urandom_range(0, 3) != 0);
            step(r, t, b, rdy, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
